// File: rtl/aes_bus_rx.sv
// aes_bus_rx: byte-bus ingress stage for the AES core.
// Assembles key/text blocks, holds the address and encdec registers,
// and acks each completed frame with the sender's source_id.
// Optional frame-idle timeout: define AES_RX_TIMEOUT_EN.
module aes_bus_rx #(
    parameter int unsigned BLOCK_BYTES    = 16,
    parameter int unsigned ADDR_BYTES     = 3,
    parameter logic [1:0]  MY_ID          = 2'b01,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                data_in,
    input  logic                      valid_in,
    output logic                      ready_in,
    input  logic [1:0]                opcode,
    input  logic [1:0]                source_id,
    input  logic [1:0]                dest_id,
    output logic [8*BLOCK_BYTES-1:0]  blk_data,
    output logic                      blk_is_key,
    output logic                      blk_valid,
    input  logic                      blk_ready,
    output logic [8*ADDR_BYTES-1:0]   addr_o,
    output logic                      encdec_o,
    output logic                      start_pulse,
    output logic                      ack_valid,
    input  logic                      ack_ready,
    output logic [1:0]                module_source_id,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int unsigned BW = 8 * BLOCK_BYTES;
    localparam int unsigned AW = 8 * ADDR_BYTES;
    localparam int unsigned CW = $clog2(BLOCK_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_DROP,
        S_HANDOFF,
        S_ACK
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      op_q, op_d;
    logic [1:0]      src_q, src_d;
    logic [BW-1:0]   shift_q, shift_d;
    logic [BW-1:0]   blk_data_q, blk_data_d;
    logic            is_key_q, is_key_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            encdec_q, encdec_d;
    logic            start_q, start_d;
    logic [1:0]      msid_q, msid_d;

    logic            accept;
    logic            done;
    logic [1:0]      done_op;
    logic [1:0]      done_src;

`ifdef AES_RX_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]   idle_q, idle_d;
    logic            terr_q, terr_d;
`endif

    // Index of the last byte of a frame with the given opcode.
    function automatic logic [CW-1:0] last_idx(input logic [1:0] op);
        case (op)
            2'b00, 2'b01: return CW'(BLOCK_BYTES - 1);
            2'b10:        return CW'(ADDR_BYTES - 1);
            default:      return '0;
        endcase
    endfunction

    assign ready_in = (state_q == S_IDLE) || (state_q == S_RECV) || (state_q == S_DROP);
    assign accept   = valid_in && ready_in;

    // Next-state, assembly and register-update logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        src_d      = src_q;
        shift_d    = shift_q;
        blk_data_d = blk_data_q;
        is_key_d   = is_key_q;
        addr_d     = addr_q;
        encdec_d   = encdec_q;
        start_d    = 1'b0;
        msid_d     = msid_q;
        done       = 1'b0;
        done_op    = op_q;
        done_src   = src_q;
`ifdef AES_RX_TIMEOUT_EN
        idle_d     = '0;
        terr_d     = terr_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d     = opcode;
                    src_d    = source_id;
                    done_op  = opcode;
                    done_src = source_id;
                    if (dest_id == MY_ID) begin
                        shift_d = {{(BW-8){1'b0}}, data_in};
                        if (last_idx(opcode) == '0) begin
                            done = 1'b1;
                        end else begin
                            state_d = S_RECV;
                            cnt_d   = CW'(1);
                        end
                    end else if (last_idx(opcode) != '0) begin
                        // a foreign 1-byte frame is already fully consumed
                        state_d = S_DROP;
                        cnt_d   = CW'(1);
                    end
                end
            end
            S_RECV: begin
                if (accept) begin
                    shift_d = {shift_q[BW-9:0], data_in};
                    if (cnt_q == last_idx(op_q)) begin
                        done = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DROP: begin
                if (accept) begin
                    if (cnt_q == last_idx(op_q)) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_HANDOFF: begin
                if (blk_ready) begin
                    state_d = S_ACK;
                    msid_d  = src_q;
                end
            end
            S_ACK: begin
                if (ack_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Frame completion, shared by the IDLE (1-byte) and RECV paths.
        if (done) begin
            cnt_d = '0;
            case (done_op)
                2'b00, 2'b01: begin
                    state_d    = S_HANDOFF;
                    blk_data_d = shift_d;
                    is_key_d   = (done_op == 2'b00);
                end
                2'b10: begin
                    state_d = S_ACK;
                    addr_d  = shift_d[AW-1:0];
                    msid_d  = done_src;
                end
                default: begin
                    state_d  = S_ACK;
                    encdec_d = data_in[0];
                    start_d  = data_in[1];
                    msid_d   = done_src;
                end
            endcase
        end

`ifdef AES_RX_TIMEOUT_EN
        if (((state_q == S_RECV) || (state_q == S_DROP)) && !accept) begin
            if (idle_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_d = S_IDLE;
                cnt_d   = '0;
                terr_d  = 1'b1;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
`endif
    end

    // State and register storage with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            src_q      <= '0;
            shift_q    <= '0;
            blk_data_q <= '0;
            is_key_q   <= 1'b0;
            addr_q     <= '0;
            encdec_q   <= 1'b0;
            start_q    <= 1'b0;
            msid_q     <= '0;
`ifdef AES_RX_TIMEOUT_EN
            idle_q     <= '0;
            terr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            src_q      <= src_d;
            shift_q    <= shift_d;
            blk_data_q <= blk_data_d;
            is_key_q   <= is_key_d;
            addr_q     <= addr_d;
            encdec_q   <= encdec_d;
            start_q    <= start_d;
            msid_q     <= msid_d;
`ifdef AES_RX_TIMEOUT_EN
            idle_q     <= idle_d;
            terr_q     <= terr_d;
`endif
        end
    end

    assign blk_data         = blk_data_q;
    assign blk_is_key       = is_key_q;
    assign blk_valid        = (state_q == S_HANDOFF);
    assign addr_o           = addr_q;
    assign encdec_o         = encdec_q;
    assign start_pulse      = start_q;
    assign ack_valid        = (state_q == S_ACK);
    assign module_source_id = msid_q;
    assign busy             = (state_q != S_IDLE);
`ifdef AES_RX_TIMEOUT_EN
    assign timeout_err      = terr_q;
`else
    assign timeout_err      = 1'b0;
`endif

endmodule

// File: tb/tb_aes_bus_rx.sv
// Testbench for aes_bus_rx: directed and randomized frames against a
// byte-list reference model of the expected registers and handshakes.
module tb_aes_bus_rx;

`ifdef AES_RX_TIMEOUT_EN
    localparam int unsigned TO = 8;
`else
    localparam int unsigned TO = 255;
`endif

    logic         clk;
    logic         rst;
    logic [7:0]   data_in;
    logic         valid_in;
    logic         ready_in;
    logic [1:0]   opcode;
    logic [1:0]   source_id;
    logic [1:0]   dest_id;
    logic [127:0] blk_data;
    logic         blk_is_key;
    logic         blk_valid;
    logic         blk_ready;
    logic [23:0]  addr_o;
    logic         encdec_o;
    logic         start_pulse;
    logic         ack_valid;
    logic         ack_ready;
    logic [1:0]   module_source_id;
    logic         busy;
    logic         timeout_err;

    int passed = 0;
    int total  = 0;
    int bv_seen = 0;
    int ack_seen = 0;

    logic [127:0] m_blk;
    logic [23:0]  m_addr;
    logic         m_enc;

    aes_bus_rx #(
        .BLOCK_BYTES(16),
        .ADDR_BYTES(3),
        .MY_ID(2'b01),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .data_in(data_in),
        .valid_in(valid_in),
        .ready_in(ready_in),
        .opcode(opcode),
        .source_id(source_id),
        .dest_id(dest_id),
        .blk_data(blk_data),
        .blk_is_key(blk_is_key),
        .blk_valid(blk_valid),
        .blk_ready(blk_ready),
        .addr_o(addr_o),
        .encdec_o(encdec_o),
        .start_pulse(start_pulse),
        .ack_valid(ack_valid),
        .ack_ready(ack_ready),
        .module_source_id(module_source_id),
        .busy(busy),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (blk_valid === 1'b1) bv_seen++;
        if (ack_valid === 1'b1) ack_seen++;
    end

    // One complete frame: drive bytes, then check the outcome the model predicts.
    task automatic run_frame(input logic [1:0] op, input logic [1:0] src, input logic [1:0] dst,
                             input int stall, input bit use_pat, input logic [127:0] pat);
        logic [7:0]   b [16];
        logic [127:0] eb;
        logic [23:0]  ea;
        int           len;
        int           bv0;
        int           ak0;
        len = (op <= 2'd1) ? 16 : ((op == 2'd2) ? 3 : 1);
        eb = '0;
        ea = '0;
        for (int i = 0; i < len; i++) begin
            b[i] = use_pat ? pat[127 - 8*i -: 8] : 8'($urandom_range(0, 255));
            if (op <= 2'd1) eb[8*(15-i) +: 8] = b[i];
            if (op == 2'd2) ea[8*(2-i) +: 8] = b[i];
        end
        bv0 = bv_seen;
        ak0 = ack_seen;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            valid_in = 1'b1;
            data_in  = b[i];
            if (i == 0) begin
                opcode = op; source_id = src; dest_id = dst;
            end else begin
                opcode = 2'($urandom); source_id = 2'($urandom); dest_id = 2'($urandom);
            end
            @(posedge clk);
        end
        #1;
        valid_in = 1'b0;

        if (dst != 2'b01) begin
            total++; if (busy !== 1'b0) $display("FAIL drop_busy: got %b want 0", busy); else passed++;
            total++; if (addr_o !== m_addr) $display("FAIL drop_addr: got %h want %h", addr_o, m_addr); else passed++;
            total++; if (blk_data !== m_blk) $display("FAIL drop_blk: got %h want %h", blk_data, m_blk); else passed++;
            total++; if (encdec_o !== m_enc) $display("FAIL drop_enc: got %b want %b", encdec_o, m_enc); else passed++;
            @(posedge clk); #1;
            total++;
            if ((bv_seen - bv0) + (ack_seen - ak0) != 0)
                $display("FAIL drop_no_handshake: got %0d valid/ack cycles want 0", (bv_seen - bv0) + (ack_seen - ak0));
            else passed++;
        end else begin
            if (op <= 2'd1) begin
                total++; if (blk_valid !== 1'b1) $display("FAIL blk_valid: got %b want 1", blk_valid); else passed++;
                total++; if (blk_data !== eb) $display("FAIL blk_data: got %h want %h", blk_data, eb); else passed++;
                total++; if (blk_is_key !== (op == 2'b00)) $display("FAIL blk_is_key: got %b want %b", blk_is_key, op == 2'b00); else passed++;
                total++; if (ready_in !== 1'b0) $display("FAIL handoff_ready: got %b want 0", ready_in); else passed++;
                for (int s = 0; s < stall; s++) begin
                    valid_in = 1'b1;
                    data_in  = 8'hEE;
                    @(posedge clk); #1;
                    total++;
                    if ({blk_valid, ready_in} !== 2'b10 || blk_data !== eb)
                        $display("FAIL stall_hold: got valid=%b ready=%b data=%h want 1 0 %h", blk_valid, ready_in, blk_data, eb);
                    else passed++;
                end
                valid_in  = 1'b0;
                blk_ready = 1'b1;
                @(posedge clk); #1;
                blk_ready = 1'b0;
                m_blk = eb;
                total++; if (blk_valid !== 1'b0) $display("FAIL blk_valid_drop: got %b want 0", blk_valid); else passed++;
            end else if (op == 2'd2) begin
                m_addr = ea;
                total++; if (addr_o !== ea) $display("FAIL addr: got %h want %h", addr_o, ea); else passed++;
            end else begin
                m_enc = b[0][0];
                total++; if (encdec_o !== b[0][0]) $display("FAIL encdec: got %b want %b", encdec_o, b[0][0]); else passed++;
                total++; if (start_pulse !== b[0][1]) $display("FAIL start_pulse: got %b want %b", start_pulse, b[0][1]); else passed++;
            end
            total++; if (ack_valid !== 1'b1) $display("FAIL ack_valid: got %b want 1", ack_valid); else passed++;
            total++; if (module_source_id !== src) $display("FAIL ack_src: got %b want %b", module_source_id, src); else passed++;
            @(posedge clk); #1;
            total++;
            if ({ack_valid, busy, start_pulse} !== 3'b110)
                $display("FAIL ack_hold: got ack=%b busy=%b start=%b want 1 1 0", ack_valid, busy, start_pulse);
            else passed++;
            ack_ready = 1'b1;
            @(posedge clk); #1;
            ack_ready = 1'b0;
            total++;
            if ({ack_valid, busy} !== 2'b00) $display("FAIL ack_done: got ack=%b busy=%b want 0 0", ack_valid, busy);
            else passed++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; valid_in = 1'b0; data_in = '0; opcode = '0; source_id = '0; dest_id = '0;
        blk_ready = 1'b0; ack_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_blk = '0; m_addr = '0; m_enc = 1'b0;
        total++; if (ready_in !== 1'b1) $display("FAIL rst_ready: got %b want 1", ready_in); else passed++;
        total++; if (blk_data !== 128'd0) $display("FAIL rst_blk: got %h want 0", blk_data); else passed++;
        total++; if (addr_o !== 24'd0) $display("FAIL rst_addr: got %h want 0", addr_o); else passed++;
        total++;
        if ({blk_valid, blk_is_key, encdec_o, start_pulse, ack_valid, module_source_id, busy, timeout_err} !== 9'd0)
            $display("FAIL rst_ctrl: got %b want 0", {blk_valid, blk_is_key, encdec_o, start_pulse, ack_valid, module_source_id, busy, timeout_err});
        else passed++;
    endtask

    task automatic test_key();
        run_frame(2'b00, 2'b10, 2'b01, 0, 1'b1, 128'h000102030405060708090a0b0c0d0e0f);
    endtask

    task automatic test_text_stall();
        run_frame(2'b01, 2'b11, 2'b01, 5, 1'b0, '0);
    endtask

    task automatic test_addr_cmd();
        run_frame(2'b10, 2'b00, 2'b01, 0, 1'b1, {24'h123456, 104'd0});
        run_frame(2'b11, 2'b10, 2'b01, 0, 1'b1, {8'h03, 120'd0});
        run_frame(2'b11, 2'b01, 2'b01, 0, 1'b1, {8'h00, 120'd0});
    endtask

    task automatic test_drop();
        run_frame(2'b00, 2'b01, 2'b10, 0, 1'b0, '0);
        run_frame(2'b11, 2'b01, 2'b00, 0, 1'b1, {8'h03, 120'd0});
        run_frame(2'b01, 2'b01, 2'b01, 1, 1'b0, '0);
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            valid_in = 1'b1; data_in = 8'($urandom);
            opcode = 2'b00; source_id = 2'b11; dest_id = 2'b01;
            @(posedge clk);
        end
        @(negedge clk);
        valid_in = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_blk = '0; m_addr = '0; m_enc = 1'b0;
        total++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else passed++;
        total++;
        if ({blk_data, addr_o, encdec_o, ack_valid, module_source_id} !== '0)
            $display("FAIL midrst_regs: got blk=%h addr=%h enc=%b ack=%b src=%b want all 0", blk_data, addr_o, encdec_o, ack_valid, module_source_id);
        else passed++;
        run_frame(2'b00, 2'b01, 2'b01, 0, 1'b0, '0);
    endtask

    task automatic test_back_to_back();
        run_frame(2'b11, 2'b00, 2'b01, 0, 1'b0, '0);
        run_frame(2'b10, 2'b11, 2'b01, 0, 1'b0, '0);
        run_frame(2'b00, 2'b10, 2'b01, 0, 1'b0, '0);
        run_frame(2'b10, 2'b01, 2'b11, 0, 1'b0, '0);
        run_frame(2'b10, 2'b01, 2'b01, 0, 1'b0, '0);
    endtask

    task automatic test_random();
        logic [1:0] op;
        logic [1:0] dst;
        for (int n = 0; n < 24; n++) begin
            op  = 2'($urandom);
            dst = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b01;
            run_frame(op, 2'($urandom), dst, $urandom_range(0, 3), 1'b0, '0);
        end
    endtask

`ifdef AES_RX_TIMEOUT_EN
    task automatic test_timeout();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            valid_in = 1'b1; data_in = 8'($urandom);
            opcode = 2'b00; source_id = 2'b10; dest_id = 2'b01;
            @(posedge clk);
        end
        #1 valid_in = 1'b0;
        repeat (TO - 1) @(posedge clk);
        #1;
        total++; if (busy !== 1'b1) $display("FAIL to_before: got busy=%b want 1", busy); else passed++;
        @(posedge clk); #1;
        total++;
        if ({busy, timeout_err, ack_valid} !== 3'b010)
            $display("FAIL to_fire: got busy=%b err=%b ack=%b want 0 1 0", busy, timeout_err, ack_valid);
        else passed++;
        total++; if (blk_data !== m_blk) $display("FAIL to_blk: got %h want %h", blk_data, m_blk); else passed++;
        run_frame(2'b01, 2'b10, 2'b01, 0, 1'b0, '0);
        total++; if (timeout_err !== 1'b1) $display("FAIL to_sticky: got %b want 1", timeout_err); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_key();
        test_text_stall();
        test_addr_cmd();
        test_drop();
        test_reset_midframe();
        test_back_to_back();
        test_random();
`ifdef AES_RX_TIMEOUT_EN
        test_timeout();
`else
        total++; if (timeout_err !== 1'b0) $display("FAIL to_tied: got %b want 0", timeout_err); else passed++;
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/aes_bus_rx.md
Name: aes_bus_rx

Overview:
- Upstream ingress stage for the AES core.
- Accepts byte frames from the shared 8-bit bus using the valid/ready, opcode, source_id and dest_id sideband.
- Assembles 128-bit key or text blocks and hands each block to the core over a valid/ready handshake.
- Holds the 24-bit address and encdec configuration registers, and returns a per-frame ack tagged with the sender's source_id.

Parameters:
- BLOCK_BYTES, 16: bytes per key or text frame.
- ADDR_BYTES, 3: bytes per address frame; addr_o is 8*ADDR_BYTES wide.
- MY_ID, 2'b01: dest_id this block answers to.
- TIMEOUT_CYCLES, 255: idle-cycle limit inside a frame; used only with the optional feature.

Ports:
- clk, in, 1: single clock; all logic on rising edge.
- rst, in, 1: synchronous, active-high reset.
- data_in, in, 8: bus byte.
- valid_in, in, 1: data_in valid.
- ready_in, out, 1: block can accept a byte.
- opcode, in, 2: 00 LOAD_KEY, 01 LOAD_TEXT, 10 LOAD_ADDR, 11 CMD.
- source_id, in, 2: sender id.
- dest_id, in, 2: target id.
- blk_data, out, 128: assembled block.
- blk_is_key, out, 1: 1 = key, 0 = text.
- blk_valid, out, 1: block offered to core.
- blk_ready, in, 1: core accepts block.
- addr_o, out, 24: address register.
- encdec_o, out, 1: 0 = encrypt, 1 = decrypt.
- start_pulse, out, 1: one-cycle start strobe.
- ack_valid, out, 1: frame complete.
- ack_ready, in, 1: sender consumes ack.
- module_source_id, out, 2: source_id latched for the current ack.
- busy, out, 1: state is not IDLE.
- timeout_err, out, 1: sticky frame-abort flag.

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE, byte counter=0.
  - blk_data=0, blk_valid=0, blk_is_key=0, addr_o=0, encdec_o=0, start_pulse=0.
  - ack_valid=0, module_source_id=0, timeout_err=0.
  - A partial frame is discarded.
- Byte acceptance: a byte is accepted on a cycle with valid_in && ready_in. ready_in is 1 in IDLE, RECV and DROP, and 0 in HANDOFF and ACK. ready_in is combinational from state, so it is 1 on the first cycle after reset.
- Frame length by opcode: BLOCK_BYTES for 00/01, ADDR_BYTES for 10, 1 for 11.
- Frame header latch:
  - opcode, source_id and dest_id are latched on the first accepted byte of a frame (in IDLE) only.
  - Changes to these inputs mid-frame are ignored.
- Byte order: MSB first. The first byte lands in blk_data[127:120] (addr: addr_o[23:16]). Each later byte shifts in one byte lower.
- IDLE, on an accepted byte:
  - dest_id==MY_ID: go to RECV. A 1-byte frame (CMD) completes in the same cycle, with the transitions listed under RECV.
  - Otherwise: go to DROP.
- RECV: the counter increments per accepted byte. On the last byte:
  - 00/01: go to HANDOFF, blk_valid=1 next cycle, blk_is_key = (opcode==00).
  - 10: addr_o updates with the completed value on the next cycle; go to ACK.
  - 11: encdec_o <= data_in[0]; start_pulse=1 for exactly the next cycle if data_in[1]=1; go to ACK.
- The assembly shift register is separate from blk_data. blk_data updates only on entry to HANDOFF and is stable while blk_valid=1.
- HANDOFF:
  - blk_valid is held until blk_valid && blk_ready; then blk_valid=0 and state goes to ACK.
  - blk_ready high on the first valid cycle transfers on that cycle.
- ACK:
  - ack_valid=1 and module_source_id = the latched source_id, held until ack_ready=1.
  - On that edge: ack_valid=0, state goes to IDLE.
  - ack_ready asserted while ack_valid=0 has no effect.
- DROP: bytes are accepted and discarded for the latched frame length. There is no ack and no register update; state returns to IDLE.
- Back-to-back frames: the first byte of the next frame is accepted on the first IDLE cycle after ACK completes.
- Counter width: clog2(BLOCK_BYTES). No wrap-around, since the counter clears on frame end.

Optional Feature:
- Macro: AES_RX_TIMEOUT_EN.
- With the macro defined:
  - An idle counter runs in RECV and DROP and clears on each accepted byte.
  - When it reaches TIMEOUT_CYCLES consecutive cycles without a byte, the partial frame is discarded, state goes to IDLE, and timeout_err is set.
  - No ack is issued and no register is updated.
  - timeout_err clears only on rst.
- Without the macro: no counter is built, timeout_err is tied 0, and a frame waits indefinitely.

Test Plan:
- LOAD_KEY, dest=01, src=10, bytes 00..0F, blk_ready=1 → blk_valid one cycle, blk_data=0x000102…0F, blk_is_key=1; then ack_valid with module_source_id=10; ack_ready=1 → IDLE.
- LOAD_TEXT with blk_ready=0 for 5 cycles after frame end → blk_valid and blk_data stable for those cycles, ready_in=0, and a byte offered meanwhile is not accepted.
- LOAD_ADDR bytes 12,34,56 → addr_o=0x123456; CMD byte 0x03 → encdec_o=1, start_pulse high exactly 1 cycle; each frame is acked.
- LOAD_KEY with dest_id=10 → 16 bytes accepted, no blk_valid, no ack, addr_o/blk_data unchanged; the next frame to 01 completes normally.
- rst asserted after byte 7 of a key frame → all outputs reset; a new 16-byte frame produces only the new data.
- With AES_RX_TIMEOUT_EN and TIMEOUT_CYCLES=8: stall 8 cycles after byte 3 → IDLE, timeout_err=1, no ack; a full frame afterwards succeeds with timeout_err still 1.
